poly_tone_mixer: RTL and testbench

- Parametrised polyphonic square-wave tone generator for the keyboard audio path.
- Replaces the single time-multiplexed tone counter with NUM_VOICES independent voice counters.
- A sequential scan mixer produces one saturated signed sample.
- Adds octave shift, click-free gating (a key change takes effect only at a voice's period wrap), and a mute control.
- Output feeds the left/right audio-out sum ahead of Audio_Controller.

---
 rtl/poly_tone_mixer.sv | 122 ++++++++++++
 tb/tb_poly_tone_mixer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/poly_tone_mixer.sv
// Polyphonic square-wave tone generator: one free-running period counter per voice,
// gated at each voice's own wrap, plus a one-voice-per-clock scan mixer with saturation.
module poly_tone_mixer #(
  parameter int NUM_VOICES = 13,
  parameter int CNT_W      = 18,
  parameter int SAMPLE_W   = 32,
  parameter int AMP        = 100000000,
  parameter logic [NUM_VOICES*CNT_W-1:0] PERIODS = {
    18'd95556,  18'd101238, 18'd107259, 18'd113636, 18'd120395,
    18'd127551, 18'd135139, 18'd143172, 18'd151685, 18'd160705,
    18'd170265, 18'd180388, 18'd191113}
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [NUM_VOICES-1:0] en,
  input  logic [1:0]            octave,
  input  logic                  mute,
  output logic [SAMPLE_W-1:0]   mix_out,
  output logic                  mix_strobe,
  output logic [NUM_VOICES-1:0] active,
  output logic                  sat_flag
);

  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES + 1);
  localparam int KW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_VOICES - 1);

  localparam logic signed [ACC_W-1:0] AMP_POS = ACC_W'(AMP);
  localparam logic signed [ACC_W-1:0] AMP_NEG = -AMP_POS;
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  logic [CNT_W-1:0]        cnt     [NUM_VOICES];
  logic [CNT_W-1:0]        half    [NUM_VOICES];
  logic [CNT_W-1:0]        per_eff [NUM_VOICES];
  logic [NUM_VOICES-1:0]   phase;
  logic signed [ACC_W-1:0] contrib [NUM_VOICES];

  logic [KW-1:0]           k;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] c_sel;
  logic signed [ACC_W-1:0] sum;

  // half[] is latched with the period so the phase threshold only moves at a wrap.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      per_eff[i] = PERIODS[i*CNT_W +: CNT_W] >> octave;
      phase[i]   = (cnt[i] >= half[i]);
      if (!active[i])
        contrib[i] = '0;
      else if (phase[i])
        contrib[i] = AMP_POS;
      else
        contrib[i] = AMP_NEG;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        cnt[i]  <= '0;
        half[i] <= '0;
      end
      active <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (cnt[i] == '0) begin
          cnt[i]    <= per_eff[i] - 1'b1;
          half[i]   <= per_eff[i] >> 1;
          active[i] <= en[i];
        end else begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    c_sel = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (KW'(i) == k) c_sel = contrib[i];
    end
    sum = acc + c_sel;
  end

  // The last scan slot folds in its own voice and latches the result in the same edge.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      k          <= '0;
      acc        <= '0;
      mix_out    <= '0;
      mix_strobe <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      mix_strobe <= 1'b0;
      if (k == K_LAST) begin
        k          <= '0;
        acc        <= '0;
        mix_strobe <= 1'b1;
        if (mute) begin
          mix_out  <= '0;
          sat_flag <= 1'b0;
        end else if (sum > SAT_MAX) begin
          mix_out  <= SAT_MAX[SAMPLE_W-1:0];
          sat_flag <= 1'b1;
        end else if (sum < SAT_MIN) begin
          mix_out  <= SAT_MIN[SAMPLE_W-1:0];
          sat_flag <= 1'b1;
        end else begin
          mix_out  <= sum[SAMPLE_W-1:0];
          sat_flag <= 1'b0;
        end
      end else begin
        acc <= sum;
        k   <= k + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_poly_tone_mixer.sv
// Bench for poly_tone_mixer: two instances (AMP=100 and AMP=16000) against a
// time-based voice model and a scan-slot mixer model with an expected-sample queue.
module tb_poly_tone_mixer;

  localparam int NV = 3;

  logic        clk;
  logic        reset;
  logic [2:0]  en;
  logic [1:0]  octave;
  logic        mute;

  logic [15:0] mix_a, mix_b;
  logic        strobe_a, strobe_b;
  logic [2:0]  active_a, active_b;
  logic        sat_a, sat_b;

  int checks   = 0;
  int failures = 0;

  poly_tone_mixer #(
    .NUM_VOICES(3), .CNT_W(8), .SAMPLE_W(16), .AMP(100),
    .PERIODS({8'd20, 8'd12, 8'd8})
  ) dut_a (
    .CLOCK_50(clk), .reset(reset), .en(en), .octave(octave), .mute(mute),
    .mix_out(mix_a), .mix_strobe(strobe_a), .active(active_a), .sat_flag(sat_a)
  );

  poly_tone_mixer #(
    .NUM_VOICES(3), .CNT_W(8), .SAMPLE_W(16), .AMP(16000),
    .PERIODS({8'd20, 8'd12, 8'd8})
  ) dut_b (
    .CLOCK_50(clk), .reset(reset), .en(en), .octave(octave), .mute(mute),
    .mix_out(mix_b), .mix_strobe(strobe_b), .active(active_b), .sat_flag(sat_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: each voice is a sequence of periods, each with its own
  // length, gate and age; the mixer visits one voice per clock.
  int          per_tab [NV] = '{8, 12, 20};
  int          m_age  [NV];
  int          m_len  [NV];
  bit          m_gate [NV];
  int          m_slot;
  int          m_units;
  bit          m_strobe;
  int          n_model_strobes;
  int          n_dut_strobes;
  logic [16:0] exp_a_q[$];
  logic [16:0] exp_b_q[$];
  logic [16:0] cur_a, cur_b;

  function automatic logic [16:0] exp_sample(input int units, input int amp, input bit m);
    int s;
    s = units * amp;
    if (m) return 17'd0;
    if (s > 32767) return {1'b1, 16'h7fff};
    if (s < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(s)};
  endfunction

  function automatic int voice_units(input int i);
    if (!m_gate[i]) return 0;
    // first ceil(len/2) clocks of a period are the high half
    if (m_age[i] < m_len[i] - m_len[i] / 2) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_age[i]  = 0;
      m_len[i]  = 1;
      m_gate[i] = 1'b0;
    end
    m_slot   = 0;
    m_units  = 0;
    m_strobe = 1'b0;
    exp_a_q.delete();
    exp_b_q.delete();
    cur_a = '0;
    cur_b = '0;
  endtask

  task automatic model_step();
    m_units  = m_units + voice_units(m_slot);
    m_strobe = 1'b0;
    if (m_slot == NV - 1) begin
      exp_a_q.push_back(exp_sample(m_units, 100, mute));
      exp_b_q.push_back(exp_sample(m_units, 16000, mute));
      m_units  = 0;
      m_slot   = 0;
      m_strobe = 1'b1;
      n_model_strobes++;
    end else begin
      m_slot++;
    end
    for (int i = 0; i < NV; i++) begin
      if (m_age[i] + 1 >= m_len[i]) begin
        m_len[i]  = per_tab[i] >> octave;
        m_age[i]  = 0;
        m_gate[i] = en[i];
      end else begin
        m_age[i]++;
      end
    end
  endtask

  always @(posedge clk) if (!reset) model_step();

  // scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      logic [2:0] m_active;
      for (int i = 0; i < NV; i++) m_active[i] = m_gate[i];
      check("strobe_a", strobe_a, m_strobe);
      check("strobe_b", strobe_b, m_strobe);
      if (strobe_a) n_dut_strobes++;
      if (m_strobe) begin
        if (exp_a_q.size() > 0) cur_a = exp_a_q.pop_front();
        if (exp_b_q.size() > 0) cur_b = exp_b_q.pop_front();
      end
      check("mix_a", mix_a, cur_a[15:0]);
      check("sat_a", sat_a, cur_a[16]);
      check("mix_b", mix_b, cur_b[15:0]);
      check("sat_b", sat_b, cur_b[16]);
      check("active_a", active_a, m_active);
      check("active_b", active_b, m_active);
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic reset_check();
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_mix_a", mix_a, 16'd0);
    check("rst_mix_b", mix_b, 16'd0);
    check("rst_strobe", {strobe_a, strobe_b}, 2'b00);
    check("rst_active", {active_a, active_b}, 6'd0);
    check("rst_sat", {sat_a, sat_b}, 2'b00);
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    en     = 3'b000;
    octave = 2'd0;
    mute   = 1'b0;
    n_model_strobes = 0;
    n_dut_strobes   = 0;
    model_reset();
    tick(3);
    reset = 1'b0;

    tick(10);
    en = 3'b001;
    tick(40);
    en = 3'b111;
    tick(60);

    // drop en0 shortly after voice 0 wraps
    for (int n = 0; n < 20 && m_age[0] != 1; n++) tick(1);
    en = 3'b110;
    tick(20);
    en = 3'b111;
    tick(5);

    octave = 2'd1;
    tick(40);
    octave = 2'd0;
    tick(20);

    mute = 1'b1;
    tick(30);
    mute = 1'b0;
    tick(10);

    reset_check();
    tick(20);

    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 9) == 0) en = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) octave = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) mute = ~mute;
      if (c == 250) reset_check();
      tick(1);
    end

    en     = 3'b000;
    mute   = 1'b0;
    octave = 2'd0;
    tick(60);
    check("idle_mix_a", mix_a, 16'd0);

    check("strobe_count", n_dut_strobes, n_model_strobes);
    check("queue_a_empty", exp_a_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
